// File: rtl/adf_reg_scheduler.sv
// Purpose : sequences every ADF435x register write: power-up load R5..R0 from shadows, then
//           round-robin between frequency (INT/FRAC -> R0) and raw-register requesters.
// Latency : INIT_DELAY cycles to first wr_start; request ack is combinational in IDLE and
//           wr_start follows one cycle after the grant.
// Backpressure: requests are level-held and acked only in IDLE with the writer idle; each word
//           waits for writer busy rise/fall plus GAP_CYCLES; there is no timeout.
// Ports   : i_clk/i_rst (sync, active-high); i_freq_* and o_freq_ack/o_freq_err frequency requester;
//           i_reg_* and o_reg_ack/o_reg_err raw requester; o_wr_start/o_wr_word/i_wr_busy serial
//           writer handshake; o_init_done after power-up load; o_busy whenever not IDLE.
module adf_reg_scheduler #(
   parameter int unsigned INIT_DELAY = 1000,
   parameter int unsigned GAP_CYCLES = 100,
   parameter logic [31:0] R5_INIT    = 32'h0018_0005,
   parameter logic [31:0] R4_INIT    = 32'h00D6_403C,
   parameter logic [31:0] R3_INIT    = 32'h0102_FFFB,
   parameter logic [31:0] R2_INIT    = 32'h0000_0442,
   parameter logic [31:0] R1_INIT    = 32'h0000_0321,
   parameter logic [31:0] R0_INIT    = 32'h0050_0000,
   parameter int unsigned INT_MIN    = 23
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_freq_req,
   input  logic [15:0] i_freq_int,
   input  logic [11:0] i_freq_frac,
   output logic        o_freq_ack,
   output logic        o_freq_err,
   input  logic        i_reg_req,
   input  logic [2:0]  i_reg_addr,
   input  logic [28:0] i_reg_data,
   output logic        o_reg_ack,
   output logic        o_reg_err,
   output logic        o_wr_start,
   output logic [31:0] o_wr_word,
   input  logic        i_wr_busy,
   output logic        o_init_done,
   output logic        o_busy
);

   typedef enum logic [2:0] {
      WAIT_INIT, INIT_ISSUE, ISSUE_WAIT_HI, ISSUE_WAIT_LO, GAP, IDLE
   } state_t;

   // Round-robin pointer holds the last granted requester.
   localparam logic RR_FREQ = 1'b0;
   localparam logic RR_REG  = 1'b1;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_cnt;
   logic [2:0]  r_idx;
   logic        r_init_run;
   logic        r_init_done;
   logic        r_rr;
   logic        r_wr_start;
   logic [31:0] r_wr_word;
   logic [31:0] r_shadow [0:5];

   logic        w_init_issue;
   logic        w_gnt_freq;
   logic        w_gnt_reg;
   logic        w_freq_bad;
   logic        w_reg_bad;
   logic [31:0] w_freq_word;
   logic [31:0] w_reg_word;

   assign w_freq_word = {1'b0, i_freq_int, i_freq_frac, 3'b000};
   assign w_reg_word  = {i_reg_data, i_reg_addr};
   assign w_freq_bad  = (i_freq_int < 16'(INT_MIN));
   assign w_reg_bad   = (i_reg_addr > 3'd5);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= WAIT_INIT;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_init_issue = 1'b0;
      w_gnt_freq   = 1'b0;
      w_gnt_reg    = 1'b0;
      case (r_state)
         WAIT_INIT:     if (r_cnt == INIT_DELAY - 1) w_state_nxt = INIT_ISSUE;
         INIT_ISSUE: begin
            if (!i_wr_busy) begin
               w_init_issue = 1'b1;
               w_state_nxt  = ISSUE_WAIT_HI;
            end
         end
         ISSUE_WAIT_HI: if (i_wr_busy)  w_state_nxt = ISSUE_WAIT_LO;
         ISSUE_WAIT_LO: if (!i_wr_busy) w_state_nxt = GAP;
         GAP: begin
            if (r_cnt == GAP_CYCLES - 1)
               w_state_nxt = (r_init_run && r_idx != 3'd0) ? INIT_ISSUE : IDLE;
         end
         IDLE: begin
            // Freq wins when it is alone, or when both are pending and reg was served last.
            if (!i_wr_busy) begin
               if (i_freq_req && (!i_reg_req || r_rr == RR_REG)) begin
                  w_gnt_freq = 1'b1;
                  if (!w_freq_bad) w_state_nxt = ISSUE_WAIT_HI;
               end else if (i_reg_req) begin
                  w_gnt_reg = 1'b1;
                  if (!w_reg_bad) w_state_nxt = ISSUE_WAIT_HI;
               end
            end
         end
         default: w_state_nxt = WAIT_INIT;
      endcase
      if (i_rst) begin
         w_init_issue = 1'b0;
         w_gnt_freq   = 1'b0;
         w_gnt_reg    = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt       <= '0;
         r_idx       <= 3'd5;
         r_init_run  <= 1'b0;
         r_init_done <= 1'b0;
         r_rr        <= RR_FREQ;
         r_wr_start  <= 1'b0;
         r_wr_word   <= '0;
         r_shadow[0] <= R0_INIT;
         r_shadow[1] <= R1_INIT;
         r_shadow[2] <= R2_INIT;
         r_shadow[3] <= R3_INIT;
         r_shadow[4] <= R4_INIT;
         r_shadow[5] <= R5_INIT;
      end else begin
         r_wr_start <= 1'b0;
         // One counter serves both the power-up delay and the inter-word gap.
         if (w_state_nxt == r_state && (r_state == WAIT_INIT || r_state == GAP))
            r_cnt <= r_cnt + 32'd1;
         else
            r_cnt <= '0;
         if (r_state == WAIT_INIT && w_state_nxt == INIT_ISSUE) begin
            r_idx      <= 3'd5;
            r_init_run <= 1'b1;
         end
         if (r_state == GAP && w_state_nxt == INIT_ISSUE)
            r_idx <= r_idx - 3'd1;
         if (r_state == GAP && w_state_nxt == IDLE && r_init_run) begin
            r_init_run  <= 1'b0;
            r_init_done <= 1'b1;
         end
         // Capture the power-up word so it stays stable after the state moves on.
         if (w_init_issue)
            r_wr_word <= r_shadow[r_idx];
         if (w_gnt_freq) begin
            r_rr <= RR_FREQ;
            if (!w_freq_bad) begin
               r_shadow[0] <= w_freq_word;
               r_wr_word   <= w_freq_word;
               r_wr_start  <= 1'b1;
            end
         end
         if (w_gnt_reg) begin
            r_rr <= RR_REG;
            if (!w_reg_bad) begin
               r_shadow[i_reg_addr] <= w_reg_word;
               r_wr_word            <= w_reg_word;
               r_wr_start           <= 1'b1;
            end
         end
      end
   end

   // Power-up words launch straight from INIT_ISSUE; request words launch one cycle after grant.
   assign o_wr_start  = w_init_issue | r_wr_start;
   assign o_wr_word   = w_init_issue ? r_shadow[r_idx] : r_wr_word;
   assign o_freq_ack  = w_gnt_freq;
   assign o_freq_err  = w_gnt_freq & w_freq_bad;
   assign o_reg_ack   = w_gnt_reg;
   assign o_reg_err   = w_gnt_reg & w_reg_bad;
   assign o_init_done = r_init_done;
   assign o_busy      = (r_state != IDLE);

endmodule
